uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per serial bit (legal range 2..255).
REQ-002 SHALL have parameter PARITY_EN, default 1, parity bit inserted between data and stop when 1.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tx_en  input  1  enable; low freezes all state, counters and tx.
REQ-007 SHALL have port tx_start  input  1  single-cycle request to send tx_data.
REQ-008 SHALL have port tx_data  input  8  byte to transmit; sampled only on acceptance.
REQ-009 SHALL have port tx  output  1  serial line; idle high.
REQ-010 SHALL have port Busy  output  1  frame in progress.
REQ-011 SHALL have port Done  output  1  one-cycle pulse at frame end.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL accept a request only when state=IDLE, tx_en=1 and tx_start=1: latch tx_data, compute parity, go to START, set Busy=1.
REQ-014 SHALL drive tx=0 from the cycle after acceptance; START lasts exactly CLKS_PER_BIT enabled cycles.
REQ-015 SHALL send 8 data bits LSB first in DATA, each held CLKS_PER_BIT enabled cycles, bit index 0..7.
REQ-016 SHALL, if PARITY_EN=1, send one parity bit = XOR of data (even) or its inverse (odd); if PARITY_EN=0, skip PARITY entirely.
REQ-017 SHALL drive tx=1 for CLKS_PER_BIT cycles in STOP, then return to IDLE with Busy=0 and Done=1 for exactly one cycle.
REQ-018 SHALL give frame length (10 + PARITY_EN) * CLKS_PER_BIT enabled cycles from first tx=0 to Done.
REQ-019 SHALL ignore tx_start while Busy=1; latched byte unchanged; no queuing.
REQ-020 SHALL accept tx_start in the same cycle Done=1 (back-to-back), with no extra idle bit beyond the stop bit.
REQ-021 SHALL, while tx_en=0, hold state, bit counter, baud counter, tx and Busy; Done pulse not generated or extended during freeze.
REQ-022 SHALL ignore tx_start while tx_en=0.
REQ-023 SHALL drive tx from a register (glitch-free; no combinational path from inputs to tx).
REQ-024 SHALL size the baud counter to ceil(log2(CLKS_PER_BIT)) bits, wrapping from CLKS_PER_BIT-1 to 0 at each bit boundary.

Reset
REQ-025 SHALL, on rst=1, asynchronously force state=IDLE, tx=1, Busy=0, Done=0, counters=0, shift register=0.
REQ-026 SHALL, on reset mid-frame, abandon the frame immediately (tx high in the same cycle); no Done issued.
REQ-027 SHALL accept a new request on the first enabled edge after rst deasserts.

Structure
REQ-028 SHALL place state encoding and parity-mode constants in shared package uart_pkg, also used by the receiver.
REQ-029 SHALL use one sub-module uart_bit_timer (baud counter with enable, clear and bit-tick output); FSM and shift register stay in uart_tx.

Verification
REQ-030 SHALL verify: defaults, tx_start with 0xA5 -> tx 0,1,0,1,0,0,1,0,1,(parity 0),1, each 8 cycles; Done at cycle 88.
REQ-031 SHALL verify: PARITY_ODD=1, 0x00 -> parity bit 1; PARITY_EN=0, 0xFF -> 80-cycle frame, no parity bit.
REQ-032 SHALL verify: tx_start with 0x3C, then tx_start with 0x55 at cycle 20 -> 0x3C frame unaltered; 0x55 never sent.
REQ-033 SHALL verify: 0x81 then 0x7E, second tx_start on the Done cycle -> second start bit follows first stop bit directly.
REQ-034 SHALL verify: tx_en low for 5 cycles mid-DATA -> current bit stretched by exactly 5 cycles; frame content intact.
REQ-035 SHALL verify: rst pulse at cycle 30 of a frame -> tx=1, Busy=0 immediately, no Done; loopback into the receiver with CLKS_PER_BIT matched -> received byte equals sent byte, no error.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants shared by the UART transmitter and receiver:
//               FSM state encoding, parity-mode codes and a parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Request/status bundle of the UART transmitter.
//               master : drives tx_en, tx_start, tx_data; observes tx, Busy, Done
//               slave  : the transmitter side of the same bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    logic       tx_en;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       Busy;
    logic       Done;

    modport master (output tx_en, tx_start, tx_data, input tx, Busy, Done);
    modport slave  (input tx_en, tx_start, tx_data, output tx, Busy, Done);
endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Baud counter. Counts enabled cycles 0..CLKS_PER_BIT-1 and
//               raises o_tick on the last cycle of every bit period.
// Ports       : clk, rst (async, active high)
//               i_en   - advance the counter this cycle
//               i_clr  - hold the counter at zero (has priority over i_en)
//               o_tick - last cycle of the current bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_clr,
    output logic      o_tick
);

    localparam int               CNT_W  = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter: start bit, 8 data bits LSB first, optional
//               parity bit, one stop bit. tx_en low freezes the whole block.
// Ports       : clk  - sole clock, rising edge
//               rst  - asynchronous, active-high reset
//               bus  - uart_tx_if.slave (tx_en, tx_start, tx_data -> tx, Busy, Done)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_tx_if.slave  bus
);
    import uart_pkg::*;

    localparam logic c_ODD = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_par;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic        w_tick;

    // Counter is parked at zero while idle so START always gets a full bit.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (bus.tx_en),
        .i_clr  (r_state == ST_IDLE),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Done is a single-cycle pulse even if the block is frozen.
            r_done <= 1'b0;
            if (bus.tx_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.tx_start) begin
                            r_shift   <= bus.tx_data;
                            r_par     <= calc_parity(bus.tx_data, c_ODD);
                            r_bit_idx <= '0;
                            r_tx      <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (w_tick) begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (w_tick) begin
                            if (r_bit_idx == 3'd7) begin
                                if (PARITY_EN != 0) begin
                                    r_tx    <= r_par;
                                    r_state <= ST_PARITY;
                                end else begin
                                    r_tx    <= 1'b1;
                                    r_state <= ST_STOP;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_tx      <= r_shift[0];
                                r_shift   <= {1'b0, r_shift[7:1]};
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_tick) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (w_tick) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx   = r_tx;
    assign bus.Busy = r_busy;
    assign bus.Done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Three instances cover
//               even parity, odd parity and no parity. Expected line values
//               come from the frame rules (bit index = cycle / CLKS_PER_BIT);
//               a behavioural receiver decodes instance 0 for loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [7:0] sent_q [$];

    uart_tx_if bus0 ();
    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // ---------------- behavioural loopback receiver on instance 0 ----------
    logic       rx_act;
    int         rx_cnt;
    logic [10:0] rx_bits;
    logic [7:0] rx_byte [0:63];
    logic       rx_err  [0:63];
    int         rx_n = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (bus0.tx_en) begin
            if (!rx_act) begin
                if (bus0.tx == 1'b0) begin
                    rx_act <= 1'b1;
                    rx_cnt <= 1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1;
                if ((rx_cnt % CPB) == (CPB / 2)) begin
                    if ((rx_cnt / CPB) == 10) begin
                        if (rx_n < 64) begin
                            rx_byte[rx_n] <= rx_bits[8:1];
                            rx_err[rx_n]  <= (rx_bits[0] != 1'b0) ||
                                             (rx_bits[9] != (^rx_bits[8:1])) ||
                                             (bus0.tx != 1'b1);
                        end
                        rx_n   <= rx_n + 1;
                        rx_act <= 1'b0;
                    end else begin
                        rx_bits[rx_cnt / CPB] <= bus0.tx;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drv(input int w, input logic en, input logic st, input logic [7:0] d);
        case (w)
            0: begin bus0.tx_en = en; bus0.tx_start = st; bus0.tx_data = d; end
            1: begin bus1.tx_en = en; bus1.tx_start = st; bus1.tx_data = d; end
            default: begin bus2.tx_en = en; bus2.tx_start = st; bus2.tx_data = d; end
        endcase
    endtask

    function automatic logic get_tx(input int w);
        case (w)
            0: return bus0.tx;
            1: return bus1.tx;
            default: return bus2.tx;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0: return bus0.Busy;
            1: return bus1.Busy;
            default: return bus2.Busy;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0: return bus0.Done;
            1: return bus1.Done;
            default: return bus2.Done;
        endcase
    endfunction

    function automatic int pe_of(input int w);
        return (w == 2) ? 0 : 1;
    endfunction

    function automatic int odd_of(input int w);
        return (w == 1) ? 1 : 0;
    endfunction

    // Line value k cycles after the first start-bit cycle.
    function automatic logic exp_bit(input logic [7:0] d, input int pe, input int odd, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && pe != 0) return (^d) ^ (odd != 0);
        return 1'b1;
    endfunction

    task automatic idle_chk(input int w, input string tag);
        chk({tag, " tx"},   {15'd0, get_tx(w)},   16'd1);
        chk({tag, " busy"}, {15'd0, get_busy(w)}, 16'd0);
        chk({tag, " done"}, {15'd0, get_done(w)}, 16'd0);
    endtask

    // Called with tx_start already driven high for the accepting edge.
    task automatic check_frame(input int w, input logic [7:0] d,
                               input int frz_at, input int frz_len,
                               input int ins_at, input logic [7:0] ins_d,
                               input int abort_at, input bit b2b, input logic [7:0] nd);
        int pe, odd, len, k, fz;
        string tg;
        pe  = pe_of(w);
        odd = odd_of(w);
        len = (10 + pe) * CPB;
        k   = 0;
        fz  = 0;
        while (k < len) begin
            @(negedge clk);
            drv(w, 1'b1, 1'b0, 8'($urandom));
            tg = $sformatf("w%0d d=%02h k=%0d", w, d, k);
            chk({tg, " tx"},   {15'd0, get_tx(w)},   {15'd0, exp_bit(d, pe, odd, k)});
            chk({tg, " busy"}, {15'd0, get_busy(w)}, 16'd1);
            chk({tg, " done"}, {15'd0, get_done(w)}, 16'd0);
            if (k == abort_at) return;
            if (frz_len > 0 && k == frz_at && fz < frz_len) begin
                drv(w, 1'b0, 1'b1, 8'($urandom));
                fz++;
            end else begin
                if (k == ins_at) drv(w, 1'b1, 1'b1, ins_d);
                k++;
            end
        end
        @(negedge clk);
        drv(w, 1'b1, 1'b0, 8'($urandom));
        tg = $sformatf("w%0d d=%02h end", w, d);
        chk({tg, " done"}, {15'd0, get_done(w)}, 16'd1);
        chk({tg, " busy"}, {15'd0, get_busy(w)}, 16'd0);
        chk({tg, " tx"},   {15'd0, get_tx(w)},   16'd1);
        if (w == 0) sent_q.push_back(d);
        if (b2b) drv(w, 1'b1, 1'b1, nd);
    endtask

    task automatic after_frame(input int w, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            idle_chk(w, $sformatf("w%0d post%0d", w, i));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] d;
        int w;
        for (int i = 0; i < 3; i++) drv(i, 1'b1, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) idle_chk(i, $sformatf("reset w%0d", i));

        // First request on the first edge after reset release.
        rst = 1'b0;
        drv(0, 1'b1, 1'b1, 8'hA5);
        check_frame(0, 8'hA5, -1, 0, -1, 8'h00, -1, 1'b0, 8'h00);
        after_frame(0, 2);

        // Odd parity of 0x00 is 1.
        @(negedge clk);
        drv(1, 1'b1, 1'b1, 8'h00);
        check_frame(1, 8'h00, -1, 0, -1, 8'h00, -1, 1'b0, 8'h00);
        after_frame(1, 2);

        // No parity: 80-cycle frame.
        @(negedge clk);
        drv(2, 1'b1, 1'b1, 8'hFF);
        check_frame(2, 8'hFF, -1, 0, -1, 8'h00, -1, 1'b0, 8'h00);
        after_frame(2, 2);

        // Request while busy is dropped.
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 8'h3C);
        check_frame(0, 8'h3C, -1, 0, 20, 8'h55, -1, 1'b0, 8'h00);
        after_frame(0, 3 * CPB);

        // Back-to-back on the Done cycle.
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 8'h81);
        check_frame(0, 8'h81, -1, 0, -1, 8'h00, -1, 1'b1, 8'h7E);
        check_frame(0, 8'h7E, -1, 0, -1, 8'h00, -1, 1'b0, 8'h00);
        after_frame(0, 2);

        // Five frozen cycles inside data bit 3.
        d = 8'($urandom);
        @(negedge clk);
        drv(0, 1'b1, 1'b1, d);
        check_frame(0, d, 30, 5, -1, 8'h00, -1, 1'b0, 8'h00);
        after_frame(0, 2);

        // Request while disabled is ignored.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv(0, 1'b0, 1'b1, 8'($urandom));
            idle_chk(0, $sformatf("en_low%0d", i));
        end
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 8'h00);
        idle_chk(0, "en_low_end");
        after_frame(0, 1);

        // Random frames on random instances.
        for (int n = 0; n < 6; n++) begin
            w = int'($urandom_range(0, 2));
            d = 8'($urandom);
            @(negedge clk);
            drv(w, 1'b1, 1'b1, d);
            check_frame(w, d, -1, 0, -1, 8'h00, -1, 1'b0, 8'h00);
            after_frame(w, 1);
        end

        // Reset at cycle 30 of a frame.
        d = 8'($urandom);
        @(negedge clk);
        drv(0, 1'b1, 1'b1, d);
        check_frame(0, d, -1, 0, -1, 8'h00, 30, 1'b0, 8'h00);
        #2 rst = 1'b1;
        #1 idle_chk(0, "rst_async");
        @(negedge clk);
        idle_chk(0, "rst_hold");
        rst = 1'b0;
        d = 8'($urandom);
        drv(0, 1'b1, 1'b1, d);
        check_frame(0, d, -1, 0, -1, 8'h00, -1, 1'b0, 8'h00);
        after_frame(0, CPB);

        // Loopback: every completed instance-0 frame decoded cleanly.
        chk("rx_count", 16'(rx_n), 16'(sent_q.size()));
        for (int i = 0; i < sent_q.size() && i < 64 && i < rx_n; i++) begin
            chk($sformatf("rx_byte%0d", i), {8'd0, rx_byte[i]}, {8'd0, sent_q[i]});
            chk($sformatf("rx_err%0d", i),  {15'd0, rx_err[i]}, 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
